// File: rtl/im_arbiter_if.sv
// Bus between the instruction-memory arbiter, its two requesters and the im read port.
// slave = arbiter side, master = requester/memory side.
interface im_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        conflicts;

  modport slave (
    input  req0, addr0, req1, addr1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, conflicts
  );

  modport master (
    output req0, addr0, req1, addr1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, conflicts
  );
endinterface

// File: rtl/im_arbiter.sv
// Two-port arbiter for the single-read-port instruction memory, one access per cycle.
// Define IM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module im_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  im_arbiter_if.slave  bus
);
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  addr_t      mem_addr_q, mem_addr_d;
  logic       last_q, last_d;
  logic [7:0] conflicts_q, conflicts_d;
  logic       both;
  logic       pick1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = gnt0_q;
    rvalid1_d   = gnt1_q;
    mem_addr_d  = mem_addr_q;
    last_d      = last_q;
    conflicts_d = conflicts_q;
    pick1       = 1'b0;
    both        = bus.req0 & bus.req1;

    if (both) begin
`ifdef IM_ARB_RR_EN
      pick1 = ~last_q;
`else
      pick1 = 1'b0;
`endif
      if (conflicts_q != 8'hFF) conflicts_d = conflicts_q + 8'd1;
    end else begin
      pick1 = bus.req1;
    end

    if (bus.req0 | bus.req1) begin
      if (pick1) begin
        gnt1_d     = 1'b1;
        mem_addr_d = bus.addr1;
        last_d     = 1'b1;
      end else begin
        gnt0_d     = 1'b1;
        mem_addr_d = bus.addr0;
        last_d     = 1'b0;
      end
    end
  end

  // last resets to 1 so the first contention after reset goes to port 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_addr_q  <= '0;
      last_q      <= 1'b1;
      conflicts_q <= 8'd0;
    end else begin
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      mem_addr_q  <= mem_addr_d;
      last_q      <= last_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.conflicts = conflicts_q;
  // The memory output is already registered; rdata is only meaningful under an rvalid strobe.
  assign bus.rdata     = data_t'(bus.mem_rdata);
endmodule

// File: tb/tb_im_arbiter.sv
// Self-checking bench for im_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_im_arbiter;
`ifdef IM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] inst [256];

  im_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  im_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory with a registered read port.
  always @(posedge clk) bus.mem_rdata <= inst[bus.mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1);
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // g / rv: 0 = none, 1 = port 0, 2 = port 1
  typedef struct {
    logic       r0;
    logic [7:0] a0;
    logic       r1;
    logic [7:0] a1;
    int         g;
    int         maddr;
    int         rv;
    int         rdata;
  } vec_t;

  function automatic vec_t mk(logic r0, logic [7:0] a0, logic r1, logic [7:0] a1,
                              int g, int maddr, int rv, int rdata);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.g = g; v.maddr = maddr; v.rv = rv; v.rdata = rdata;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input int g, input int maddr,
                               input int rv, input int rdata);
    check({tag, ".gnt0"}, 32'(bus.gnt0), 32'(g == 1));
    check({tag, ".gnt1"}, 32'(bus.gnt1), 32'(g == 2));
    check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(maddr));
    check({tag, ".rvalid0"}, 32'(bus.rvalid0), 32'(rv == 1));
    check({tag, ".rvalid1"}, 32'(bus.rvalid1), 32'(rv == 2));
    if (rv != 0) check({tag, ".rdata"}, bus.rdata, 32'(rdata));
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl [13];

  // Reference model state (transaction level).
  int m_gnt, m_addr, m_rv, m_rdata, m_last, m_conf;

  task automatic model_edge(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1);
    int winner;
    m_rv    = m_gnt;
    m_rdata = int'(inst[m_addr]);
    winner  = 0;
    if (r0 && r1) begin
      m_conf++;
      winner = (RR && m_last == 0) ? 2 : 1;
    end else if (r0) winner = 1;
    else if (r1) winner = 2;
    m_gnt = winner;
    if (winner == 1) begin m_addr = int'(a0); m_last = 0; end
    if (winner == 2) begin m_addr = int'(a1); m_last = 1; end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) inst[i] = 32'(i * 40);
    drive(1'b0, 8'd0, 1'b0, 8'd0);

    // ---------------- reset state ----------------
    tick();
    tick();
    rst = 1'b0;
    check_outputs("reset", 0, 0, 0, 0);
    check("reset.conflicts", 32'(bus.conflicts), 32'd0);

    // ---------------- directed table ----------------
    tbl[0]  = mk(1, 75, 0, 0,  1, 75, 0, 0);
    tbl[1]  = mk(0, 0,  0, 0,  0, 75, 1, 3000);
    tbl[2]  = mk(1, 10, 0, 0,  1, 10, 0, 0);
    tbl[3]  = mk(1, 11, 0, 0,  1, 11, 1, 400);
    tbl[4]  = mk(1, 12, 0, 0,  1, 12, 1, 440);
    tbl[5]  = mk(0, 0,  0, 0,  0, 12, 1, 480);
    tbl[6]  = mk(0, 0,  1, 5,  2, 5,  0, 0);
    tbl[7]  = mk(1, 20, 1, 30, 1, 20, 2, 200);
`ifdef IM_ARB_RR_EN
    tbl[8]  = mk(1, 20, 1, 30, 2, 30, 1, 800);
    tbl[9]  = mk(1, 20, 1, 30, 1, 20, 2, 1200);
    tbl[10] = mk(1, 20, 1, 30, 2, 30, 1, 800);
    tbl[11] = mk(0, 0,  0, 0,  0, 30, 2, 1200);
`else
    tbl[8]  = mk(1, 20, 1, 30, 1, 20, 1, 800);
    tbl[9]  = mk(1, 20, 1, 30, 1, 20, 1, 800);
    tbl[10] = mk(1, 20, 1, 30, 1, 20, 1, 800);
    tbl[11] = mk(0, 0,  0, 0,  0, 20, 1, 800);
`endif
    tbl[12] = mk(0, 0,  0, 0,  0, RR ? 30 : 20, 0, 0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1);
      tick();
      check_outputs($sformatf("vec%0d", i), tbl[i].g, tbl[i].maddr, tbl[i].rv, tbl[i].rdata);
    end
    check("vec.conflicts", 32'(bus.conflicts), 32'd4);

    // ---------------- async reset with a grant in flight ----------------
    drive(1'b0, 8'd0, 1'b1, 8'd75);
    tick();
    check("inflight.gnt1", 32'(bus.gnt1), 32'd1);
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    rst = 1'b1;
    #1;
    check("async.gnt1", 32'(bus.gnt1), 32'd0);
    check("async.mem_addr", 32'(bus.mem_addr), 32'd0);
    check("async.conflicts", 32'(bus.conflicts), 32'd0);
    @(posedge clk);
    #1;
    check("async.rvalid1", 32'(bus.rvalid1), 32'd0);
    check("async.rvalid0", 32'(bus.rvalid0), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst.rvalid1", 32'(bus.rvalid1), 32'd0);
    drive(1'b0, 8'd0, 1'b1, 8'd75);
    tick();
    check_outputs("rereq.grant", 2, 75, 0, 0);
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    tick();
    check_outputs("rereq.data", 0, 75, 2, 3000);

    // ---------------- conflict counter saturation ----------------
    drive(1'b1, 8'd1, 1'b1, 8'd2);
    for (int i = 0; i < 100; i++) tick();
    check("sat.conflicts100", 32'(bus.conflicts), 32'd100);
    for (int i = 0; i < 160; i++) tick();
    check("sat.conflicts255", 32'(bus.conflicts), 32'd255);
    drive(1'b0, 8'd0, 1'b0, 8'd0);
    tick();
    check("sat.hold", 32'(bus.conflicts), 32'd255);

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_gnt = 0; m_addr = 0; m_rv = 0; m_rdata = 0; m_last = 1; m_conf = 0;
    for (int i = 0; i < 400; i++) begin
      logic       r0, r1;
      logic [7:0] a0, a1;
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      drive(r0, a0, r1, a1);
      tick();
      model_edge(r0, a0, r1, a1);
      check_outputs($sformatf("rnd%0d", i), m_gnt, m_addr, m_rv, m_rdata);
      check($sformatf("rnd%0d.conflicts", i), 32'(bus.conflicts),
            32'((m_conf > 255) ? 255 : m_conf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/im_arbiter.md
# im_arbiter

Two-port arbiter that shares the single-read-port instruction memory (`im`: 256 × 32-bit words, 8-bit address, output registered on `posedge clk`) between two requesters. Port 0 is the fetch stage; port 1 is the loader/debug reader. The arbiter registers the winning address onto the memory address bus and returns the memory word to the winner with a valid strobe. It sustains one access per cycle.

## Interface
- `ADDR_W`, default 8: address width; matches the `im` address port.
- `DATA_W`, default 32: word width; matches the `im` data port.

- `clk` input 1: single clock; all state updates on `posedge clk`.
- `rst` input 1: asynchronous, active-high reset.
- `req0` input 1: port 0 request; level-sensitive.
- `addr0` input `ADDR_W`: port 0 address; valid while `req0`=1.
- `req1` input 1: port 1 request.
- `addr1` input `ADDR_W`: port 1 address.
- `gnt0` output 1: registered one-cycle grant pulse for port 0.
- `gnt1` output 1: registered one-cycle grant pulse for port 1.
- `rvalid0` output 1: `rdata` holds port 0's word this cycle.
- `rvalid1` output 1: `rdata` holds port 1's word this cycle.
- `rdata` output `DATA_W`: shared return data; combinational pass-through of `mem_rdata`.
- `mem_addr` output `ADDR_W`: registered address to `im.addr`.
- `mem_rdata` input `DATA_W`: from `im.IOut`.
- `conflicts` output 8: saturating count of cycles in which both requests were sampled high.

## Operation
- At each edge, the arbiter samples `req0`/`req1`:
  - Neither high: `gnt0`=`gnt1`=0 and `mem_addr` holds its value.
  - One high: grant that port.
  - Both high: resolve per Configuration and increment `conflicts`. The counter saturates at 255.
- On a grant to port i:
  - `mem_addr` <= `addr_i`.
  - `gnt_i` <= 1 for exactly one cycle.
  - `last` <= i.
- Return path: `rvalid_i` is `gnt_i` delayed by one register stage. While `rvalid_i`=1, `rdata` = `mem_rdata` = `inst[mem_addr of the grant]`.
- At most one of `gnt0`/`gnt1` is high in any cycle. The same holds for `rvalid0`/`rvalid1`.
- Handshake rules:
  - The requester holds `req_i` and `addr_i` stable until it sees `gnt_i`=1.
  - During the `gnt_i` cycle the requester either deasserts `req_i` or presents its next address before the next edge.
  - A `req_i` still high at that edge is a new request.
- Dropping `req_i` before a grant withdraws the request. No grant is issued for it.
- Reset, asynchronous: `gnt0`=`gnt1`=0, `rvalid0`=`rvalid1`=0, `mem_addr`=0, `conflicts`=0, `last`=1.
  - With `last`=1, the first contention after reset goes to port 0.
- Reset mid-operation: in-flight `rvalid` strobes are cancelled. A granted access whose `rvalid` has not yet appeared is lost and must be re-requested.

## Timing
- `req_i` sampled high at edge E → `gnt_i`=1 in cycle E..E+1 with `mem_addr` updated.
- `im` captures the word at edge E+1 → `rvalid_i`=1 and `rdata` valid in cycle E+1..E+2.
- Request-to-data latency is 2 edges. Throughput is 1 word/cycle; back-to-back grants are allowed on either port or alternating.
- A losing requester waits. Under round-robin its worst-case wait is 1 extra cycle.
- `rdata` is undefined when both `rvalid` strobes are 0. It carries stale `IOut` and must not be consumed.

## Configuration
- `IM_ARB_RR_EN` defined: round-robin on contention. The port not equal to `last` wins, so continuous dual requests alternate 0,1,0,1…
- `IM_ARB_RR_EN` undefined: fixed priority, port 0 always wins contention, and port 1 can starve. `last` is still updated but ignored.
- `conflicts` counting is identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately, `mem_addr`=0, `conflicts`=0.
- Single port: `req0`=1, `addr0`=75 for one cycle, with `im` word 75 = 3000 → `gnt0` pulse next cycle, then `rvalid0`=1 with `rdata`=3000. `gnt1`/`rvalid1` stay 0.
- Streaming: `req0` held with addresses 10,11,12 on consecutive cycles → three consecutive `gnt0` pulses, then `rvalid0` for three cycles returning `inst[10]`, `inst[11]`, `inst[12]`.
- Contention, `IM_ARB_RR_EN` defined: `req0`=`req1`=1 held for 4 grants → grant order 0,1,0,1; `conflicts` counts every cycle both requests are sampled high.
- Contention, `IM_ARB_RR_EN` undefined: same stimulus → grants 0,0,0,0, port 1 never granted; `conflicts` behaves as in the round-robin build.
- Reset in flight: assert `rst` in the cycle `gnt1`=1 → no `rvalid1` follows. After release, a `req1` at `addr1`=75 returns 3000 two edges later.
